// File: rtl/seq_add_sub.sv
// ============================================================================
// Module   : seq_add_sub
// Brief    : Multi-cycle adder/subtractor that processes SLICE_WIDTH bits per
//            clock from LSB to MSB, using a START/DONE handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_add_sub #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  ci,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  co,
    output logic                  ovf,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int K_W    = $clog2(NSLICE + 1);
    localparam logic [K_W-1:0] C_LAST_K = K_W'(NSLICE);

    generate
        if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_bad_slice
            $fatal(1, "seq_add_sub: SLICE_WIDTH must divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [K_W-1:0]          r_k;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_res;
    logic                    r_carry;
    logic                    r_c_msb;

    logic [SLICE_WIDTH-1:0]  w_a_s;
    logic [SLICE_WIDTH-1:0]  w_b_s;
    logic [SLICE_WIDTH:0]    w_slice;
    logic                    w_c_msb;
    logic [DATA_WIDTH-1:0]   w_res_next;

    // Operands shift right each slice, so the active slice is always at the bottom.
    assign w_a_s   = r_a[SLICE_WIDTH-1:0];
    assign w_b_s   = r_b[SLICE_WIDTH-1:0];
    assign w_slice = {1'b0, w_a_s} + {1'b0, w_b_s} + {{SLICE_WIDTH{1'b0}}, r_carry};
    // Sum bit = a ^ b ^ cin, so the carry into the slice MSB falls out by XOR.
    assign w_c_msb = w_slice[SLICE_WIDTH-1] ^ w_a_s[SLICE_WIDTH-1] ^ w_b_s[SLICE_WIDTH-1];
    assign w_res_next = (r_res >> SLICE_WIDTH)
                      | (DATA_WIDTH'(w_slice[SLICE_WIDTH-1:0]) << (DATA_WIDTH - SLICE_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_c_msb <= 1'b0;
            y       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= op_sub ? ~b : b;
                        r_carry <= op_sub | ci;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k == C_LAST_K) begin
                        y       <= r_res;
                        co      <= r_carry;
                        ovf     <= r_c_msb ^ r_carry;
                        zero    <= (r_res == '0);
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_res   <= w_res_next;
                        r_carry <= w_slice[SLICE_WIDTH];
                        r_c_msb <= w_c_msb;
                        r_a     <= r_a >> SLICE_WIDTH;
                        r_b     <= r_b >> SLICE_WIDTH;
                        r_k     <= r_k + K_W'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_add_sub.sv
// ============================================================================
// Module   : tb_seq_add_sub
// Brief    : Directed self-checking bench for seq_add_sub (slice widths 4, 1, 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_add_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic        ci;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] y,  y1,  y32;
    logic        co, co1, co32;
    logic        ovf, ovf1, ovf32;
    logic        zero, zero1, zero32;
    logic        busy, busy1, busy32;
    logic        done, done1, done32;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_add_sub #(.DATA_WIDTH(32), .SLICE_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .ci(ci),
        .y(y), .co(co), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
    );

    seq_add_sub #(.DATA_WIDTH(32), .SLICE_WIDTH(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .ci(ci),
        .y(y1), .co(co1), .ovf(ovf1), .zero(zero1), .busy(busy1), .done(done1)
    );

    seq_add_sub #(.DATA_WIDTH(32), .SLICE_WIDTH(32)) u_dut_s32 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .ci(ci),
        .y(y32), .co(co32), .ovf(ovf32), .zero(zero32), .busy(busy32), .done(done32)
    );

    // One operation: present operands, accept, scramble inputs, then watch 40 cycles.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                         input logic isub, output int lat, output int lat1,
                         output int lat32, output int npulse);
        lat = -1; lat1 = -1; lat32 = -1; npulse = 0;
        @(negedge clk);
        a = ia; b = ib; ci = ici; op_sub = isub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; ci = ~ici; op_sub = ~isub;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                npulse++;
                if (lat < 0) lat = i;
            end
            if (done1 && lat1 < 0) lat1 = i;
            if (done32 && lat32 < 0) lat32 = i;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (y !== 32'h0) $display("FAIL reset_y: got %h expected 00000000", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero, busy, done} !== 5'b00000)
            $display("FAIL reset_flags: got %b expected 00000", {co, ovf, zero, busy, done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        int lat, lat1, lat32, np;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if (lat !== 9) $display("FAIL add_wrap_latency: got %0d expected 9", lat);
        else n_pass++;
        n_total++;
        if (np !== 1) $display("FAIL add_wrap_pulses: got %0d expected 1", np);
        else n_pass++;
        n_total++;
        if (y !== 32'h0000_0000) $display("FAIL add_wrap_y: got %h expected 00000000", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero} !== 3'b101)
            $display("FAIL add_wrap_flags: got %b expected 101", {co, ovf, zero});
        else n_pass++;

        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if (y !== 32'h8000_0000) $display("FAIL add_ovf_y: got %h expected 80000000", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero} !== 3'b010)
            $display("FAIL add_ovf_flags: got %b expected 010", {co, ovf, zero});
        else n_pass++;

        do_op(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if (y !== 32'h0000_0004) $display("FAIL add_ci_y: got %h expected 00000004", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero} !== 3'b000)
            $display("FAIL add_ci_flags: got %b expected 000", {co, ovf, zero});
        else n_pass++;
    endtask

    task automatic test_sub;
        int lat, lat1, lat32, np;
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat, lat1, lat32, np);
        n_total++;
        if (y !== 32'hFFFF_FFFE) $display("FAIL sub_neg_y: got %h expected fffffffe", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero} !== 3'b000)
            $display("FAIL sub_neg_flags: got %b expected 000", {co, ovf, zero});
        else n_pass++;

        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, lat1, lat32, np);
        n_total++;
        if (y !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_y: got %h expected 7fffffff", y);
        else n_pass++;
        n_total++;
        if ({co, ovf, zero} !== 3'b110)
            $display("FAIL sub_ovf_flags: got %b expected 110", {co, ovf, zero});
        else n_pass++;

        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, lat, lat1, lat32, np);
        n_total++;
        if ({y, co, ovf, zero} !== {32'h0, 3'b101})
            $display("FAIL sub_zero: got %h/%b expected 00000000/101", y, {co, ovf, zero});
        else n_pass++;
    endtask

    // START held high: one op per IDLE visit; busy high through RUN+DONE.
    task automatic test_back_to_back;
        logic exp_done;
        logic exp_busy;
        @(negedge clk);
        a = 32'd10; b = 32'd20; ci = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk);
            #1;
            exp_done = (i == 9) || (i == 20);
            exp_busy = !((i == 10) || (i == 21) || (i == 22));
            n_total++;
            if (done !== exp_done)
                $display("FAIL b2b_done_c%0d: got %b expected %b", i, done, exp_done);
            else n_pass++;
            n_total++;
            if (busy !== exp_busy)
                $display("FAIL b2b_busy_c%0d: got %b expected %b", i, busy, exp_busy);
            else n_pass++;
            if (i == 9) begin
                n_total++;
                if (y !== 32'd30) $display("FAIL b2b_first_y: got %0d expected 30", y);
                else n_pass++;
            end
            if (i == 20) begin
                n_total++;
                if (y !== 32'd120) $display("FAIL b2b_second_y: got %0d expected 120", y);
                else n_pass++;
            end
            if (i == 1) a = 32'd100;
            if (i == 12) b = 32'd999;
            if (i == 20) start = 1'b0;
        end
        repeat (40) @(posedge clk);
    endtask

    task automatic test_abort;
        int lat, lat1, lat32, np;
        int ndone;
        ndone = 0;
        @(negedge clk);
        a = 32'h11; b = 32'h22; ci = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({y, co, ovf, zero, busy, done} !== 37'h0)
            $display("FAIL abort_clear: got %h/%b expected 00000000/00000", y,
                     {co, ovf, zero, busy, done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_total++;
        if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", ndone);
        else n_pass++;

        do_op(32'd3, 32'd4, 1'b0, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if (y !== 32'h0000_0007) $display("FAIL abort_recover_y: got %h expected 00000007", y);
        else n_pass++;
    endtask

    task automatic test_wide_slice;
        int lat, lat1, lat32, np;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if (lat1 !== 33) $display("FAIL s1_latency: got %0d expected 33", lat1);
        else n_pass++;
        n_total++;
        if (lat32 !== 2) $display("FAIL s32_latency: got %0d expected 2", lat32);
        else n_pass++;
        n_total++;
        if ({y1, co1, ovf1, zero1} !== {32'h8000_0000, 3'b010})
            $display("FAIL s1_add_ovf: got %h/%b expected 80000000/010", y1, {co1, ovf1, zero1});
        else n_pass++;
        n_total++;
        if ({y32, co32, ovf32, zero32} !== {32'h8000_0000, 3'b010})
            $display("FAIL s32_add_ovf: got %h/%b expected 80000000/010", y32,
                     {co32, ovf32, zero32});
        else n_pass++;

        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, lat, lat1, lat32, np);
        n_total++;
        if ({y, co, ovf, zero} !== {32'hACF1_3569, 3'b000})
            $display("FAIL s4_mixed: got %h/%b expected acf13569/000", y, {co, ovf, zero});
        else n_pass++;
        n_total++;
        if ({y1, co1, ovf1, zero1} !== {32'hACF1_3569, 3'b000})
            $display("FAIL s1_mixed: got %h/%b expected acf13569/000", y1, {co1, ovf1, zero1});
        else n_pass++;

        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, lat1, lat32, np);
        n_total++;
        if ({y1, co1, ovf1, zero1} !== {32'h7FFF_FFFF, 3'b110})
            $display("FAIL s1_sub_ovf: got %h/%b expected 7fffffff/110", y1, {co1, ovf1, zero1});
        else n_pass++;
        n_total++;
        if ({y32, co32, ovf32, zero32} !== {32'h7FFF_FFFF, 3'b110})
            $display("FAIL s32_sub_ovf: got %h/%b expected 7fffffff/110", y32,
                     {co32, ovf32, zero32});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_abort();
        test_wide_slice();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
